// File: rtl/ledsuit_pkg.sv
// Shared types and default WS2812 timing for the LED-suit strip drivers.
// scale_byte is only used when WS2812_BRIGHTNESS_EN is defined.
package ledsuit_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, FETCH, SHIFT} state_t;

  localparam int DEF_TOTAL_PULSE_TIME = 70;
  localparam int DEF_ZERO_PULSE_TIME  = 20;
  localparam int DEF_ONE_PULSE_TIME   = 50;
  localparam int DEF_RESET_PULSE_TIME = 50000;

  typedef logic [7:0] LED_BYTE_T;

  // (b * (br + 1)) >> 8; br = 0xFF passes the byte through unchanged.
  function automatic LED_BYTE_T scale_byte(input LED_BYTE_T b, input logic [7:0] br);
    logic [16:0] p;
    p = 17'(b) * (17'(br) + 17'd1);
    return p[15:8];
  endfunction
endpackage

// File: rtl/ws2812_bit_timer.sv
// One WS2812 bit period: cycle counter plus registered pulse shaping of the data line.
module ws2812_bit_timer #(
  parameter int TOTAL_PULSE_TIME = 70,
  parameter int ZERO_PULSE_TIME  = 20,
  parameter int ONE_PULSE_TIME   = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_value,
  output logic led_strip_do,
  output logic bit_end
);
  localparam int CW = $clog2(TOTAL_PULSE_TIME);
  localparam logic [CW-1:0] HI1  = CW'(ONE_PULSE_TIME);
  localparam logic [CW-1:0] HI0  = CW'(ZERO_PULSE_TIME);
  localparam logic [CW-1:0] LAST = CW'(TOTAL_PULSE_TIME - 1);

  logic [CW-1:0] cnt;

  assign bit_end = start && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      led_strip_do <= 1'b0;
    end else begin
      cnt          <= (!start || bit_end) ? '0 : cnt + CW'(1);
      led_strip_do <= start && (cnt < (bit_value ? HI1 : HI0));
    end
  end
endmodule

// File: rtl/ws2812_frame_driver.sv
// Streams NUM_LEDS*BYTES_PER_LED frame-buffer bytes onto a WS2812 strip, latch gap first.
// Define WS2812_BRIGHTNESS_EN to add the brightness port and per-byte scaling.
module ws2812_frame_driver
  import ledsuit_pkg::*;
#(
  parameter int NUM_LEDS         = 160,
  parameter int BYTES_PER_LED    = 3,
  parameter int ADDR_W           = 13,
  parameter int BASE_ADDR        = 0,
  parameter int TOTAL_PULSE_TIME = DEF_TOTAL_PULSE_TIME,
  parameter int ZERO_PULSE_TIME  = DEF_ZERO_PULSE_TIME,
  parameter int ONE_PULSE_TIME   = DEF_ONE_PULSE_TIME,
  parameter int RESET_PULSE_TIME = DEF_RESET_PULSE_TIME
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic              led_strip_do
);
  localparam int NBYTES = NUM_LEDS * BYTES_PER_LED;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LCW    = $clog2(RESET_PULSE_TIME + 1);

  if (BASE_ADDR + NBYTES > (1 << ADDR_W)) begin : g_addr_chk
    $error("frame buffer does not fit in ADDR_W address bits");
  end

  state_t          state, state_nx;
  logic [LCW-1:0]  latch_cnt;
  logic            fetch_ph, rd_pend;
  logic [IDX_W-1:0] byte_idx;
  logic [2:0]      bit_idx;
  LED_BYTE_T       shift_reg, hold_reg, byte_in;
  logic            bit_end, latch_end, byte_end, last_byte, frame_end;

`ifdef WS2812_BRIGHTNESS_EN
  assign byte_in = scale_byte(mem_dout, brightness);
`else
  assign byte_in = mem_dout;
`endif

  assign busy      = (state != IDLE);
  assign latch_end = (state == LATCH) && (latch_cnt == LCW'(RESET_PULSE_TIME - 1));
  assign byte_end  = bit_end && (bit_idx == 3'd7);
  assign last_byte = (byte_idx == IDX_W'(NBYTES - 1));
  assign frame_end = byte_end && last_byte;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (enable) state_nx = LATCH;
      LATCH: if (latch_end) state_nx = FETCH;
      FETCH: if (fetch_ph) state_nx = SHIFT;
      SHIFT: if (frame_end) state_nx = enable ? LATCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte n+1 is requested at the start of byte n and parked in hold_reg until bit 7 ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_cnt  <= '0;
      fetch_ph   <= 1'b0;
      rd_pend    <= 1'b0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      hold_reg   <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= ADDR_W'(BASE_ADDR);
      frame_done <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      rd_pend    <= mem_en;
      frame_done <= frame_end;
      latch_cnt  <= (state == LATCH && !latch_end) ? latch_cnt + LCW'(1) : '0;
      fetch_ph   <= (state == FETCH) && !fetch_ph;
      if (rd_pend) hold_reg <= byte_in;
      if (latch_end) begin
        mem_en   <= 1'b1;
        mem_addr <= ADDR_W'(BASE_ADDR);
        byte_idx <= '0;
        bit_idx  <= '0;
      end
      if (state == FETCH && fetch_ph) begin
        shift_reg <= byte_in;
        if (NBYTES > 1) begin
          mem_en   <= 1'b1;
          mem_addr <= ADDR_W'(BASE_ADDR + 1);
        end
      end
      if (bit_end) begin
        if (byte_end) begin
          bit_idx   <= '0;
          shift_reg <= hold_reg;
          if (!last_byte) begin
            byte_idx <= byte_idx + IDX_W'(1);
            if (int'(byte_idx) < NBYTES - 2) begin
              mem_en   <= 1'b1;
              mem_addr <= ADDR_W'(BASE_ADDR + int'(byte_idx) + 2);
            end
          end
        end else begin
          bit_idx   <= bit_idx + 3'd1;
          shift_reg <= {shift_reg[6:0], 1'b0};
        end
      end
    end
  end

  ws2812_bit_timer #(
    .TOTAL_PULSE_TIME(TOTAL_PULSE_TIME),
    .ZERO_PULSE_TIME (ZERO_PULSE_TIME),
    .ONE_PULSE_TIME  (ONE_PULSE_TIME)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (state == SHIFT),
    .bit_value   (shift_reg[7]),
    .led_strip_do(led_strip_do),
    .bit_end     (bit_end)
  );
endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver: 2 LEDs, 100-cycle latch, synchronous 1-cycle-latency memory.
module tb_ws2812_frame_driver;
  localparam int R  = 100;
  localparam int NB = 6;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic        busy, frame_done, mem_en, led_strip_do;
  logic [12:0] mem_addr;
  logic [7:0]  mem_dout = 8'h00;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'hFF;
`endif

  logic [7:0] mem [NB];
  logic [7:0] exp_bytes [NB];
  int cyc = 0, n_assert = 0, n_fail = 0;
  int fd_count = 0, fd_cyc = 0, en_count = 0, hi_count = 0;
  int en_cyc [NB];
  int rise_t [48];

  ws2812_frame_driver #(.NUM_LEDS(2), .RESET_PULSE_TIME(R)) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .busy(busy), .frame_done(frame_done), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .led_strip_do(led_strip_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem_dout <= mem[mem_addr[2:0]];
  end

  always @(negedge clk) begin
    if (frame_done) begin fd_count++; fd_cyc = cyc; end
    if (mem_en) begin
      en_count++;
      if (mem_addr < 13'(NB)) en_cyc[mem_addr[2:0]] = cyc;
    end
    if (led_strip_do === 1'b1) hi_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output bit ok);
    int t;
    t = 0;
    while (led_strip_do !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    ok = (led_strip_do === 1'b1);
    if (!ok) check("rise_timeout", {31'b0, led_strip_do}, 1);
  endtask

  // Decode bits first..last, checking high width and rise-to-rise spacing.
  task automatic rx_bits(input int first, input int last);
    bit ok;
    int hi;
    for (int k = first; k <= last; k++) begin
      wait_rise(ok);
      if (!ok) return;
      rise_t[k] = cyc;
      hi = 0;
      while (led_strip_do === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
      check($sformatf("width[%0d]", k), hi, exp_bytes[k/8][7-k%8] ? 50 : 20);
      if (k > 0) check($sformatf("spacing[%0d]", k), rise_t[k] - rise_t[k-1], 70);
    end
  endtask

  task automatic single_frame(input string tag);
    int fd0, e_cyc, h0;
    fd0 = fd_count;
    enable = 1'b1;
    @(negedge clk);
    e_cyc = cyc;
    enable = 1'b0;
    check({tag, "_busy"}, busy, 1);
    rx_bits(0, 47);
    check({tag, "_first_rise"}, rise_t[0] - e_cyc, R + 3);
    repeat (100) @(negedge clk);
    check({tag, "_done_cnt"}, fd_count - fd0, 1);
    check({tag, "_idle"}, busy, 0);
    h0 = hi_count;
    repeat (300) @(negedge clk);
    check({tag, "_no_restart"}, hi_count - h0, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_led"}, led_strip_do, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_addr"}, mem_addr, 0);
  endtask

  initial begin
    int fd0, en0, h0, e_cyc;
    bit ok;
    mem = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'hAA, 8'h55};
    exp_bytes = mem;

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_rst");

    // Single frame: widths, spacing, prefetch lead, done pulse, address hold
    fd0 = fd_count; en0 = en_count;
    enable = 1'b1;
    @(negedge clk);
    e_cyc = cyc;
    enable = 1'b0;
    check("t1_busy", busy, 1);
    rx_bits(0, 47);
    check("t1_first_rise", rise_t[0] - e_cyc, R + 3);
    check("t1_fetch0_lead", rise_t[0] - en_cyc[0], 3);
    for (int b = 1; b < NB; b++)
      check($sformatf("t1_prefetch_lead[%0d]", b), (rise_t[8*b] - en_cyc[b]) >= 560, 1);
    repeat (100) @(negedge clk);
    check("t1_done_cnt", fd_count - fd0, 1);
    check("t1_done_time", fd_cyc - rise_t[47], 69);
    check("t1_idle", busy, 0);
    check("t1_mem_en_cnt", en_count - en0, NB);
    check("t1_addr_hold", mem_addr, NB - 1);
    h0 = hi_count;
    repeat (300) @(negedge clk);
    check("t1_no_restart", hi_count - h0, 0);

    // Back-to-back frames, then enable dropped at bit 20 of the second
    fd0 = fd_count;
    enable = 1'b1;
    rx_bits(0, 47);
    repeat (30) @(negedge clk);
    check("t2_busy_in_gap", busy, 1);
    check("t2_done_cnt1", fd_count - fd0, 1);
    rx_bits(0, 19);
    check("t2_gap", rise_t[0] - fd_cyc, R + 3);
    enable = 1'b0;
    rx_bits(20, 47);
    repeat (100) @(negedge clk);
    check("t2_done_cnt2", fd_count - fd0, 2);
    check("t2_idle", busy, 0);
    h0 = hi_count;
    repeat (300) @(negedge clk);
    check("t2_no_restart", hi_count - h0, 0);

    // Reset at bit 10, cycle 30, then a clean restart from byte 0
    mem[1] = 8'hFF;
    exp_bytes[1] = 8'hFF;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    rx_bits(0, 9);
    wait_rise(ok);
    repeat (30) @(negedge clk);
    check("t3_pre_rst_high", led_strip_do, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t3_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    single_frame("t3_restart");

`ifdef WS2812_BRIGHTNESS_EN
    // Brightness scaling
    mem = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    brightness = 8'h7F;
    exp_bytes = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    single_frame("br7f");
    brightness = 8'hFF;
    exp_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    single_frame("brff");
    mem = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'hAA, 8'h55};
    brightness = 8'h00;
    exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    single_frame("br00");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
